// File: rtl/faux_fis_send_scheduler_if.sv
// Bundle between the faux HD command layer, the FIS send scheduler and the transport layer.
// Handshake: req_*_stb and send_*_stb are one-cycle pulses. After a send strobe the transport
// takes the FIS by dropping transport_layer_ready, then ends the send by raising it again.
interface faux_fis_send_scheduler_if;
  logic       req_reg_stb;
  logic       req_dev_bits_stb;
  logic       req_pio_stb;
  logic       req_dma_act_stb;
  logic       req_data_stb;
  logic       transport_layer_ready;
  logic       xmit_error;
  logic       remote_abort;
  logic       send_reg_stb;
  logic       send_dev_bits_stb;
  logic       send_pio_stb;
  logic       send_dma_act_stb;
  logic       send_data_stb;
  logic [4:0] pending;
  logic [2:0] active_fis;
  logic       busy;
  logic       done_stb;
  logic       fail_stb;
  logic [3:0] retry_count;
  logic [1:0] state_dbg;

  modport slave (
    input  req_reg_stb, req_dev_bits_stb, req_pio_stb, req_dma_act_stb, req_data_stb,
    input  transport_layer_ready, xmit_error, remote_abort,
    output send_reg_stb, send_dev_bits_stb, send_pio_stb, send_dma_act_stb, send_data_stb,
    output pending, active_fis, busy, done_stb, fail_stb, retry_count, state_dbg
  );

  modport master (
    output req_reg_stb, req_dev_bits_stb, req_pio_stb, req_dma_act_stb, req_data_stb,
    output transport_layer_ready, xmit_error, remote_abort,
    input  send_reg_stb, send_dev_bits_stb, send_pio_stb, send_dma_act_stb, send_data_stb,
    input  pending, active_fis, busy, done_stb, fail_stb, retry_count, state_dbg
  );
endinterface

// File: rtl/faux_fis_send_scheduler.sv
// Queues FIS send requests from the command layer and issues them one at a time to the
// transport, retrying on transmit error, remote abort or ready timeout.
module faux_fis_send_scheduler #(
  parameter int MAX_RETRY     = 3,
  parameter int READY_TIMEOUT = 1024
) (
  input logic                      clk,
  input logic                      rst,
  faux_fis_send_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_RETRY     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  pending_q, pending_d;
  logic [4:0]  requeue_q, requeue_d;
  logic [4:0]  send_q, send_d;
  logic [2:0]  active_q, active_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic [4:0]  req;
  logic [4:0]  act_mask;
  logic [2:0]  pick_fis;
  logic        ready;
  logic        err_now;
  logic        decide;
  logic        finish;

  // FIS code 1..5 maps onto pending bit 0..4; code 0 means no FIS.
  function automatic logic [4:0] fis_mask(input logic [2:0] f);
    case (f)
      3'd1:    fis_mask = 5'b00001;
      3'd2:    fis_mask = 5'b00010;
      3'd3:    fis_mask = 5'b00100;
      3'd4:    fis_mask = 5'b01000;
      3'd5:    fis_mask = 5'b10000;
      default: fis_mask = 5'b00000;
    endcase
  endfunction

  assign req = {bus.req_data_stb, bus.req_dma_act_stb, bus.req_pio_stb,
                bus.req_dev_bits_stb, bus.req_reg_stb};
  assign ready    = bus.transport_layer_ready;
  assign err_now  = err_q | bus.xmit_error | bus.remote_abort;
  assign act_mask = fis_mask(active_q);

  // Descending scan so the lowest pending bit (register FIS) wins.
  always_comb begin
    pick_fis = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending_q[i]) pick_fis = 3'(i + 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    requeue_d = requeue_q;
    send_d    = 5'b00000;
    active_d  = active_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    decide    = 1'b0;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q != 5'b00000 && ready) begin
          active_d = pick_fis;
          send_d   = fis_mask(pick_fis);
          tmo_d    = '0;
          err_d    = 1'b0;
          state_d  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        err_d = err_now;
        if (!ready) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == 16'(READY_TIMEOUT - 1)) begin
          err_d  = 1'b1;
          decide = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WAIT_DONE: begin
        err_d = err_now;
        if (ready) decide = 1'b1;
      end
      S_RETRY: begin
        if (ready) begin
          send_d  = act_mask;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = S_WAIT_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      if (err_d && retry_q < 4'(MAX_RETRY)) begin
        retry_d = retry_q + 4'd1;
        state_d = S_RETRY;
      end else begin
        finish   = 1'b1;
        done_d   = !err_d;
        fail_d   = err_d;
        retry_d  = '0;
        active_d = 3'd0;
        state_d  = S_IDLE;
      end
    end

    // A re-request of the in-flight type keeps its pending bit alive past completion;
    // a fresh request always beats a same-cycle clear.
    requeue_d = requeue_q | (req & act_mask);
    if (finish) begin
      pending_d = pending_q & ~(act_mask & ~requeue_q);
      requeue_d = requeue_d & ~act_mask;
    end
    pending_d = pending_d | req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      requeue_q <= '0;
      send_q    <= '0;
      active_q  <= '0;
      retry_q   <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      requeue_q <= requeue_d;
      send_q    <= send_d;
      active_q  <= active_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.send_reg_stb      = send_q[0];
  assign bus.send_dev_bits_stb = send_q[1];
  assign bus.send_pio_stb      = send_q[2];
  assign bus.send_dma_act_stb  = send_q[3];
  assign bus.send_data_stb     = send_q[4];
  assign bus.pending           = pending_q;
  assign bus.active_fis        = active_q;
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done_stb          = done_q;
  assign bus.fail_stb          = fail_q;
  assign bus.retry_count       = retry_q;
  assign bus.state_dbg         = state_q;
endmodule

// File: tb/tb_faux_fis_send_scheduler.sv
// Bench for faux_fis_send_scheduler: vector table of single-FIS transactions plus hand-written
// sequences, with an event scoreboard fed at stimulus time and drained by an output monitor.
module tb_faux_fis_send_scheduler;
  localparam int MAX_RETRY     = 3;
  localparam int READY_TIMEOUT = 16;
  localparam int EW            = 14;
  localparam logic [1:0] K_SEND = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_FAIL = 2'd3;

  typedef struct {
    logic [4:0] req;
    int         low;
    int         errs;
    bit         abort;
    logic [2:0] fis;
    int         sends;
    bit         fail;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [EW-1:0] exp_q[$];
  vec_t tbl[7];

  faux_fis_send_scheduler_if bus();

  faux_fis_send_scheduler #(
    .MAX_RETRY(MAX_RETRY),
    .READY_TIMEOUT(READY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [4:0] send_vec();
    return {bus.send_data_stb, bus.send_dma_act_stb, bus.send_pio_stb,
            bus.send_dev_bits_stb, bus.send_reg_stb};
  endfunction

  function automatic logic [2:0] fis_of(input logic [4:0] sv);
    case (sv)
      5'b00001: return 3'd1;
      5'b00010: return 3'd2;
      5'b00100: return 3'd3;
      5'b01000: return 3'd4;
      5'b10000: return 3'd5;
      default:  return 3'd7;
    endcase
  endfunction

  function automatic logic [EW-1:0] mk_ev(input logic [1:0] kind, input logic [2:0] fis,
                                          input logic [3:0] retry, input logic [4:0] pend);
    return {kind, fis, retry, pend};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_ev(input logic [EW-1:0] got);
    logic [EW-1:0] want;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got %0h, expected no event (cycle %0d)", got, cyc);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL event: got %0h, expected %0h (cycle %0d)", got, want, cyc);
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [4:0] mon_sv;
  always @(negedge clk) begin
    if (rst) begin
      mon_sv = send_vec();
      if (mon_sv != 5'b00000)
        check_ev(mk_ev(K_SEND, fis_of(mon_sv), bus.retry_count, bus.pending));
      if (bus.done_stb)
        check_ev(mk_ev(K_DONE, bus.active_fis, bus.retry_count, bus.pending));
      if (bus.fail_stb)
        check_ev(mk_ev(K_FAIL, bus.active_fis, bus.retry_count, bus.pending));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [4:0] m);
    bus.req_reg_stb      = m[0];
    bus.req_dev_bits_stb = m[1];
    bus.req_pio_stb      = m[2];
    bus.req_dma_act_stb  = m[3];
    bus.req_data_stb     = m[4];
  endtask

  task automatic wait_strobe(output bit found, output int at_cyc);
    int t = 0;
    at_cyc = -1;
    while (send_vec() == 5'b00000 && t < 300) begin
      @(negedge clk);
      t++;
    end
    found = (send_vec() != 5'b00000);
    if (found) at_cyc = cyc;
    else begin
      n_vec++;
      n_err++;
      $display("FAIL strobe_wait: no send strobe in 300 cycles, expected one (cycle %0d)", cyc);
    end
  endtask

  // One transport attempt: take the FIS, hold ready low for 'low' cycles, optionally raise an error.
  task automatic serve(input int low, input bit err, input bit abort, input bit no_fall,
                       input logic [4:0] rereq, output int at_cyc);
    bit found;
    wait_strobe(found, at_cyc);
    if (!found) return;
    if (no_fall) begin
      @(negedge clk);
      return;
    end
    bus.transport_layer_ready = 1'b0;
    set_req(rereq);
    for (int i = 0; i < low; i++) begin
      @(negedge clk);
      set_req(5'b00000);
      bus.xmit_error   = err && !abort && (i == 0);
      bus.remote_abort = err && abort && (i == 0);
    end
    bus.xmit_error            = 1'b0;
    bus.remote_abort          = 1'b0;
    bus.transport_layer_ready = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(bus.busy == 1'b0 && exp_q.size() == 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy=%0b with %0d events outstanding, expected idle and drained",
               bus.busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- test ----------------
  int sc[4];
  int c0;
  initial begin
    tbl[0] = '{5'b00001, 3, 0, 1'b0, 3'd1, 1, 1'b0};
    tbl[1] = '{5'b00010, 4, 0, 1'b0, 3'd2, 1, 1'b0};
    tbl[2] = '{5'b00100, 2, 1, 1'b0, 3'd3, 2, 1'b0};
    tbl[3] = '{5'b01000, 3, 4, 1'b0, 3'd4, 4, 1'b1};
    tbl[4] = '{5'b10000, 5, 0, 1'b0, 3'd5, 1, 1'b0};
    tbl[5] = '{5'b00001, 3, 3, 1'b0, 3'd1, 4, 1'b0};
    tbl[6] = '{5'b00010, 3, 2, 1'b1, 3'd2, 3, 1'b0};

    set_req(5'b00000);
    bus.transport_layer_ready = 1'b1;
    bus.xmit_error            = 1'b0;
    bus.remote_abort          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send",    32'(send_vec()), 0);
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_active",  32'(bus.active_fis), 0);
    check("rst_retry",   32'(bus.retry_count), 0);
    check("rst_strobes", 32'({bus.done_stb, bus.fail_stb}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table: single request, scripted transport behaviour per attempt.
    for (int v = 0; v < 7; v++) begin
      for (int a = 0; a < tbl[v].sends; a++)
        exp_q.push_back(mk_ev(K_SEND, tbl[v].fis, 4'(a), tbl[v].req));
      exp_q.push_back(mk_ev(tbl[v].fail ? K_FAIL : K_DONE, 3'd0, 4'd0, 5'd0));
      set_req(tbl[v].req);
      @(negedge clk);
      set_req(5'b00000);
      check("pend_capture",  32'(bus.pending), 32'(tbl[v].req));
      check("no_early_send", 32'(send_vec()), 0);
      @(negedge clk);
      check("send_latency",  32'(send_vec()), 32'(tbl[v].req));
      for (int a = 0; a < tbl[v].sends; a++)
        serve(tbl[v].low, a < tbl[v].errs, tbl[v].abort, 1'b0, 5'b00000, c0);
      wait_idle();
      check("busy_after",    32'(bus.busy), 0);
      check("pending_after", 32'(bus.pending), 0);
    end

    // Data and register requested together: register goes first.
    exp_q.push_back(mk_ev(K_SEND, 3'd1, 4'd0, 5'b10001));
    exp_q.push_back(mk_ev(K_DONE, 3'd0, 4'd0, 5'b10000));
    exp_q.push_back(mk_ev(K_SEND, 3'd5, 4'd0, 5'b10000));
    exp_q.push_back(mk_ev(K_DONE, 3'd0, 4'd0, 5'b00000));
    set_req(5'b10001);
    @(negedge clk);
    set_req(5'b00000);
    check("prio_pending", 32'(bus.pending), 32'h11);
    serve(3, 1'b0, 1'b0, 1'b0, 5'b00000, c0);
    serve(3, 1'b0, 1'b0, 1'b0, 5'b00000, c0);
    wait_idle();

    // Transport never takes the PIO-setup FIS: every attempt times out.
    for (int a = 0; a < 4; a++)
      exp_q.push_back(mk_ev(K_SEND, 3'd3, 4'(a), 5'b00100));
    exp_q.push_back(mk_ev(K_FAIL, 3'd0, 4'd0, 5'b00000));
    set_req(5'b00100);
    @(negedge clk);
    set_req(5'b00000);
    for (int a = 0; a < 4; a++) serve(0, 1'b0, 1'b0, 1'b1, 5'b00000, sc[a]);
    check("timeout_gap", 32'(sc[1] - sc[0]), 32'(READY_TIMEOUT + 1));
    wait_idle();

    // Data re-requested while in flight: sent a second time.
    exp_q.push_back(mk_ev(K_SEND, 3'd5, 4'd0, 5'b10000));
    exp_q.push_back(mk_ev(K_DONE, 3'd0, 4'd0, 5'b10000));
    exp_q.push_back(mk_ev(K_SEND, 3'd5, 4'd0, 5'b10000));
    exp_q.push_back(mk_ev(K_DONE, 3'd0, 4'd0, 5'b00000));
    set_req(5'b10000);
    @(negedge clk);
    set_req(5'b00000);
    serve(3, 1'b0, 1'b0, 1'b0, 5'b10000, c0);
    serve(3, 1'b0, 1'b0, 1'b0, 5'b00000, c0);
    wait_idle();

    // Reset while waiting for the transport to finish.
    exp_q.push_back(mk_ev(K_SEND, 3'd1, 4'd0, 5'b00001));
    set_req(5'b00001);
    @(negedge clk);
    set_req(5'b00000);
    begin
      bit found;
      wait_strobe(found, c0);
    end
    bus.transport_layer_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_busy",    32'(bus.busy), 0);
    check("arst_pending", 32'(bus.pending), 0);
    check("arst_active",  32'(bus.active_fis), 0);
    check("arst_state",   32'(bus.state_dbg), 0);
    @(negedge clk);
    bus.transport_layer_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy",    32'(bus.busy), 0);
    check("post_rst_pending", 32'(bus.pending), 0);
    check("queue_drained",    32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
